// File: rtl/ne16_tcdm_splitter.sv
// Wide-to-narrow TCDM splitter: per-port grant tracking plus per-port response re-alignment.
// Optional NE16_SPLIT_BE_SKIP_EN: ports whose byte enables are all zero are neither requested nor awaited.
module ne16_tcdm_splitter #(
  parameter int unsigned MP    = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wide_req_i,
  output logic                wide_gnt_o,
  input  logic [31:0]         wide_add_i,
  input  logic                wide_wen_i,
  input  logic [MP*4-1:0]     wide_be_i,
  input  logic [MP*32-1:0]    wide_data_i,
  output logic [MP*32-1:0]    wide_r_data_o,
  output logic                wide_r_valid_o,
  output logic [MP-1:0]       tcdm_req_o,
  input  logic [MP-1:0]       tcdm_gnt_i,
  output logic [MP-1:0][31:0] tcdm_add_o,
  output logic [MP-1:0]       tcdm_wen_o,
  output logic [MP-1:0][3:0]  tcdm_be_o,
  output logic [MP-1:0][31:0] tcdm_data_o,
  input  logic [MP-1:0][31:0] tcdm_r_data_i,
  input  logic [MP-1:0]       tcdm_r_valid_i
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

  logic [MP-1:0] act, hs, done_q, done_d, head, rsp_ne, rsp_pop;
  logic          slot_ok, tx_push, tx_pop;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [PW-1:0] tx_wr_q, tx_rd_q;
  logic [MP-1:0] tx_mem_q [DEPTH];
  logic [PW-1:0] rsp_wr_q [MP];
  logic [PW-1:0] rsp_rd_q [MP];
  logic [CW-1:0] rsp_cnt_q [MP];
  logic [31:0]   rsp_mem_q [MP][DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int ii = 0; ii < MP; ii++) begin
`ifdef NE16_SPLIT_BE_SKIP_EN
      act[ii] = |wide_be_i[ii*4 +: 4];
`else
      act[ii] = 1'b1;
`endif
    end
  end

  // Handshake: a narrow port transfers on req & gnt; the wide side transfers on wide_req_i & wide_gnt_o,
  // which rises in the cycle the last outstanding active port is granted. Reads return with no backpressure.
  assign slot_ok    = ~wide_wen_i | (out_cnt_q < CNT_MAX);
  assign tcdm_req_o = {MP{wide_req_i & slot_ok & ~rst_i}} & act & ~done_q;
  assign hs         = tcdm_req_o & tcdm_gnt_i;
  assign wide_gnt_o = wide_req_i & slot_ok & ~rst_i & (&(done_q | hs | ~act));
  assign done_d     = wide_gnt_o ? '0 : (done_q | hs);

  assign tx_push        = wide_gnt_o & wide_wen_i;
  assign head           = tx_mem_q[tx_rd_q];
  assign wide_r_valid_o = (out_cnt_q != '0) & (&(rsp_ne | ~head));
  assign tx_pop         = wide_r_valid_o;
  assign rsp_pop        = {MP{tx_pop}} & head;
  assign out_cnt_d      = out_cnt_q + CW'(tx_push) - CW'(tx_pop);

  for (genvar ii = 0; ii < MP; ii++) begin : g_port
    assign tcdm_add_o[ii]  = (wide_add_i & 32'hFFFF_FFFC) + 32'(4 * ii);
    assign tcdm_wen_o[ii]  = wide_wen_i;
    assign tcdm_be_o[ii]   = wide_be_i[ii*4 +: 4];
    assign tcdm_data_o[ii] = wide_data_i[ii*32 +: 32];
    assign rsp_ne[ii]      = rsp_cnt_q[ii] != '0;
    assign wide_r_data_o[ii*32 +: 32] = head[ii] ? rsp_mem_q[ii][rsp_rd_q[ii]] : 32'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q    <= '0;
      out_cnt_q <= '0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      for (int ii = 0; ii < MP; ii++) begin
        rsp_wr_q[ii]  <= '0;
        rsp_rd_q[ii]  <= '0;
        rsp_cnt_q[ii] <= '0;
      end
    end else begin
      done_q    <= done_d;
      out_cnt_q <= out_cnt_d;
      if (tx_push) tx_wr_q <= ptr_inc(tx_wr_q);
      if (tx_pop)  tx_rd_q <= ptr_inc(tx_rd_q);
      for (int ii = 0; ii < MP; ii++) begin
        if (tcdm_r_valid_i[ii]) rsp_wr_q[ii] <= ptr_inc(rsp_wr_q[ii]);
        if (rsp_pop[ii])        rsp_rd_q[ii] <= ptr_inc(rsp_rd_q[ii]);
        rsp_cnt_q[ii] <= rsp_cnt_q[ii] + CW'(tcdm_r_valid_i[ii]) - CW'(rsp_pop[ii]);
      end
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the reset pointers and counters.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= act;
    for (int ii = 0; ii < MP; ii++) begin
      if (tcdm_r_valid_i[ii]) rsp_mem_q[ii][rsp_wr_q[ii]] <= tcdm_r_data_i[ii];
    end
  end
endmodule

// File: tb/tb_ne16_tcdm_splitter.sv
// Bench for ne16_tcdm_splitter: directed scenarios then random traffic against a memory-level reference.
`timescale 1ns/1ps
module tb_ne16_tcdm_splitter;
  localparam int MP    = 4;
  localparam int DEPTH = 2;
  localparam int W     = MP * 32;

  logic                clk = 1'b0;
  logic                rst_i;
  logic                wide_req_i, wide_gnt_o, wide_wen_i, wide_r_valid_o;
  logic [31:0]         wide_add_i;
  logic [MP*4-1:0]     wide_be_i;
  logic [W-1:0]        wide_data_i, wide_r_data_o;
  logic [MP-1:0]       tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [MP-1:0][31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [MP-1:0][3:0]  tcdm_be_o;

  always #5 clk = ~clk;

  ne16_tcdm_splitter #(.MP(MP), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wide_req_i(wide_req_i), .wide_gnt_o(wide_gnt_o), .wide_add_i(wide_add_i),
    .wide_wen_i(wide_wen_i), .wide_be_i(wide_be_i), .wide_data_i(wide_data_i),
    .wide_r_data_o(wide_r_data_o), .wide_r_valid_o(wide_r_valid_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [W-1:0]        exp_q[$];
  logic [MP-1:0]       mask_q[$];
  logic [31:0]         ref_mem [256];
  logic [31:0]         tcdm_mem [256];
  int                  rsp_cnt [MP];
  logic [MP-1:0]       granted, pend_rv;
  logic [MP-1:0][31:0] pend_data;
  logic                tk_wgnt, tk_rv;
  logic [MP-1:0]       tk_req;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MP-1:0] act_of(input logic [MP*4-1:0] be);
    logic [MP-1:0] a;
    for (int ii = 0; ii < MP; ii++) begin
`ifdef NE16_SPLIT_BE_SKIP_EN
      a[ii] = |be[ii*4 +: 4];
`else
      a[ii] = 1'b1;
`endif
    end
    return a;
  endfunction

  function automatic int widx(input logic [31:0] add, input int ii);
    return int'(add[9:2]) + ii;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic issue(input logic [31:0] add, input logic wen, input logic [MP*4-1:0] be, input logic [W-1:0] data);
    wide_add_i  = add;
    wide_wen_i  = wen;
    wide_be_i   = be;
    wide_data_i = data;
    wide_req_i  = 1'b1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    mask_q.delete();
    granted = '0;
    pend_rv = '0;
    for (int ii = 0; ii < MP; ii++) rsp_cnt[ii] = 0;
  endtask

  // One clock cycle: entered and left at posedge+1; outputs checked at the negedge.
  task automatic tick(input logic [MP-1:0] gnt);
    logic [MP-1:0] a, exp_req, hs;
    logic [W-1:0]  rd;
    logic          slot, exp_wgnt, exp_rv;
    int            wi;
    tcdm_gnt_i     = gnt;
    tcdm_r_valid_i = pend_rv;
    tcdm_r_data_i  = pend_data;
    pend_rv        = '0;
    @(negedge clk);
    a        = act_of(wide_be_i);
    slot     = !wide_wen_i || (mask_q.size() < DEPTH);
    exp_req  = (wide_req_i && slot) ? (a & ~granted) : '0;
    hs       = exp_req & gnt;
    exp_wgnt = wide_req_i && slot && ((granted | hs | ~a) == '1);
    tk_req = tcdm_req_o; tk_wgnt = wide_gnt_o; tk_rv = wide_r_valid_o;
    chk("tcdm_req", W'(tcdm_req_o), W'(exp_req));
    chk("wide_gnt", W'(wide_gnt_o), W'(exp_wgnt));
    for (int ii = 0; ii < MP; ii++) if (exp_req[ii]) begin
      chk("tcdm_add", W'(tcdm_add_o[ii]), W'((wide_add_i & ~32'h3) + 32'(4 * ii)));
      chk("tcdm_fields", W'({tcdm_wen_o[ii], tcdm_be_o[ii], tcdm_data_o[ii]}),
          W'({wide_wen_i, wide_be_i[ii*4 +: 4], wide_data_i[ii*32 +: 32]}));
    end
    exp_rv = 1'b0;
    if (mask_q.size() != 0) begin
      exp_rv = 1'b1;
      for (int ii = 0; ii < MP; ii++) if (mask_q[0][ii] && rsp_cnt[ii] == 0) exp_rv = 1'b0;
    end
    chk("r_valid", W'(wide_r_valid_o), W'(exp_rv));
    if (exp_rv) begin
      chk("r_data", wide_r_data_o, exp_q[0]);
      for (int ii = 0; ii < MP; ii++) if (mask_q[0][ii]) rsp_cnt[ii]--;
      void'(exp_q.pop_front());
      void'(mask_q.pop_front());
    end
    for (int ii = 0; ii < MP; ii++) if (tcdm_r_valid_i[ii]) begin
      rsp_cnt[ii]++;
      chk("rsp_fits", W'(rsp_cnt[ii] <= DEPTH), W'(1));
    end
    for (int ii = 0; ii < MP; ii++) if (hs[ii]) begin
      wi = widx(wide_add_i, ii);
      if (wide_wen_i) begin
        pend_rv[ii]   = 1'b1;
        pend_data[ii] = tcdm_mem[wi];
      end else begin
        tcdm_mem[wi] = merge(tcdm_mem[wi], wide_data_i[ii*32 +: 32], wide_be_i[ii*4 +: 4]);
      end
    end
    granted = granted | hs;
    if (exp_wgnt) begin
      rd = '0;
      for (int ii = 0; ii < MP; ii++) if (a[ii]) begin
        wi = widx(wide_add_i, ii);
        if (wide_wen_i) rd[ii*32 +: 32] = ref_mem[wi];
        else ref_mem[wi] = merge(ref_mem[wi], wide_data_i[ii*32 +: 32], wide_be_i[ii*4 +: 4]);
      end
      if (wide_wen_i) begin
        exp_q.push_back(rd);
        mask_q.push_back(a);
      end
      granted = '0;
    end
    @(posedge clk);
    #1;
    if (exp_wgnt) wide_req_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((wide_req_i || mask_q.size() != 0 || pend_rv != '0) && n < 100) begin
      tick('1);
      n++;
    end
    chk("drain_done", W'(wide_req_i || mask_q.size() != 0), W'(0));
  endtask

  initial begin
    logic [MP-1:0] g, exp_w;
    logic [31:0]   v;
    logic [MP*4-1:0] be;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ref_mem[i]  = v;
      tcdm_mem[i] = v;
    end
    clear_model();
    pend_data = '0;
    rst_i = 1'b1;
    issue(32'h0, 1'b1, '1, '0);
    tcdm_gnt_i = '1; tcdm_r_valid_i = '0; tcdm_r_data_i = '0;
    #12;
    chk("reset_req", W'(tcdm_req_o), W'(0));
    chk("reset_gnt", W'(wide_gnt_o), W'(0));
    chk("reset_rv", W'(wide_r_valid_o), W'(0));
    @(posedge clk); #1;
    rst_i = 1'b0;
    wide_req_i = 1'b0;

    // Aligned read, all ports granted together.
    issue(32'h100, 1'b1, '1, '0);
    tick('1);
    chk("t1_gnt", W'(tk_wgnt), W'(1));
    chk("t1_add0", W'(tcdm_add_o[0]), W'(32'h100));
    chk("t1_add3", W'(tcdm_add_o[3]), W'(32'h10C));
    tick('1);
    chk("t1_rv_c1", W'(tk_rv), W'(0));
    tick('1);
    chk("t1_rv_c2", W'(tk_rv), W'(1));
    drain();

    // Port 2 grant withheld for three cycles.
    issue(32'h202, 1'b1, '1, '0);
    for (int k = 0; k < 3; k++) begin
      tick(4'b1011);
      chk("t2_no_gnt", W'(tk_wgnt), W'(0));
      if (k > 0) chk("t2_only_p2", W'(tk_req), W'(4'b0100));
    end
    tick(4'b0100);
    chk("t2_gnt", W'(tk_wgnt), W'(1));
    tick('1);
    chk("t2_rv_c1", W'(tk_rv), W'(0));
    tick('1);
    chk("t2_rv_c2", W'(tk_rv), W'(1));
    drain();

    // Three back-to-back reads: the third waits for a free slot.
    issue(32'h40, 1'b1, '1, '0); tick('1);
    issue(32'h80, 1'b1, '1, '0); tick('1);
    issue(32'hC0, 1'b1, '1, '0); tick('1);
    chk("t3_stall_req", W'(tk_req), W'(0));
    chk("t3_first_rv", W'(tk_rv), W'(1));
    tick('1);
    chk("t3_third_gnt", W'(tk_wgnt), W'(1));
    drain();

    // Partial-enable write.
`ifdef NE16_SPLIT_BE_SKIP_EN
    exp_w = 4'b0101;
`else
    exp_w = 4'b1111;
`endif
    issue(32'h300, 1'b0, 16'h0F0F, {4{32'hA5A5_5A5A}});
    tick('1);
    chk("t4_ports", W'(tk_req), W'(exp_w));
    chk("t4_gnt", W'(tk_wgnt), W'(1));
    tick('1);
    chk("t4_no_rv", W'(tk_rv), W'(0));
    drain();

    // Reset with two reads outstanding.
    issue(32'h40, 1'b1, '1, '0); tick('1);
    issue(32'h80, 1'b1, '1, '0); tick('1);
    issue(32'hC0, 1'b1, '1, '0);
    tcdm_r_valid_i = '0;
    tcdm_gnt_i     = '0;
    #2 rst_i = 1'b1;
    #1;
    chk("rst_req", W'(tcdm_req_o), W'(0));
    chk("rst_gnt", W'(wide_gnt_o), W'(0));
    chk("rst_rv", W'(wide_r_valid_o), W'(0));
    chk("rst_out_cnt", W'(dut.out_cnt_q), W'(0));
    clear_model();
    @(posedge clk); #1;
    rst_i = 1'b0;
    tick('1);
    chk("rst_next_gnt", W'(tk_wgnt), W'(1));
    tick('1);
    tick('1);
    chk("rst_next_rv", W'(tk_rv), W'(1));
    drain();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if (!wide_req_i && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0:       be = '1;
          1:       be = '0;
          default: begin
            be = MP*4'($urandom);
            for (int ii = 0; ii < MP; ii++) if ($urandom_range(0, 2) == 0) be[ii*4 +: 4] = 4'h0;
          end
        endcase
        issue((32'($urandom_range(0, 251)) << 2) | 32'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), be, {$urandom, $urandom, $urandom, $urandom});
      end
      for (int ii = 0; ii < MP; ii++) g[ii] = ($urandom_range(0, 3) != 0);
      tick(g);
    end
    drain();
    chk("final_empty", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
